// File: rtl/datapath.sv
// ============================================================================
// datapath : 32-bit single-bus CPU datapath (GPRs, HI/LO, Z, PC, IR, MDR,
//            MAR, Y, I/O ports, ALU, CON flip-flop)   -- rev 1.0
// ============================================================================
`default_nettype none

module datapath (
  input  logic        clock,
  input  logic        clr,
  output logic [31:0] bus_contents,
  input  logic [31:0] enc_input,
  input  logic [5:0]  ALU_Sel,
  input  logic [31:0] Mdatain,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] reg_enable,
  input  logic        incPC,
  input  logic [3:0]  Gra,
  input  logic [3:0]  Grb,
  input  logic [3:0]  Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        conIn,
  output logic        CONFFOut,
  input  logic        outport1Enable,
  input  logic        strobeInport1
);

  // Bus sources that exist: R0-R15, HI, LO, Zh, Zl, PC, MDR, InPort, C
  localparam logic [31:0] c_SRC_MASK = 32'h02DF_FFFF;

  logic [31:0] r_gpr [16];
  logic [31:0] r_hi, r_lo, r_pc, r_ir, r_mdr, r_mar, r_y, r_inport, r_outport;
  logic [63:0] r_z;
  logic        r_con;

  logic [31:0] w_bus;
  logic [31:0] w_src [32];
  logic [31:0] w_csext;
  logic [63:0] w_alu;
  logic [4:0]  w_shamt;
  logic [31:0] w_shra, w_ror, w_rol, w_quot, w_rem;
  logic [63:0] w_prod;
  logic        w_cond;
  logic        w_unused;

  assign w_csext = {{13{r_ir[18]}}, r_ir[18:0]};

  always_comb begin
    for (int i = 0; i < 32; i++) w_src[i] = '0;
    for (int i = 0; i < 16; i++) w_src[i] = r_gpr[i];
    w_src[16] = r_hi;
    w_src[17] = r_lo;
    w_src[18] = r_z[63:32];
    w_src[19] = r_z[31:0];
    w_src[20] = r_pc;
    w_src[22] = r_mdr;
    w_src[23] = r_inport;
    w_src[25] = w_csext;
  end

  // Descending scan so the lowest-index requested source wins
  always_comb begin
    w_bus = '0;
    if (BAout) begin
      w_bus = (Grb == 4'd0) ? 32'd0 : r_gpr[Grb];
    end else if (Rout) begin
      w_bus = r_gpr[Grb];
    end else begin
      for (int i = 31; i >= 0; i--)
        if (enc_input[i] && c_SRC_MASK[i]) w_bus = w_src[i];
    end
  end

  assign bus_contents = w_bus;

  assign w_shamt = w_bus[4:0];
  assign w_shra  = $signed(r_y) >>> w_shamt;
  assign w_ror   = (r_y >> w_shamt) | (r_y << (6'd32 - {1'b0, w_shamt}));
  assign w_rol   = (r_y << w_shamt) | (r_y >> (6'd32 - {1'b0, w_shamt}));
  assign w_prod  = $signed({{32{r_y[31]}}, r_y}) * $signed({{32{w_bus[31]}}, w_bus});
  assign w_quot  = $signed(r_y) / $signed(w_bus);
  assign w_rem   = $signed(r_y) % $signed(w_bus);

  always_comb begin
    w_alu = {32'd0, w_bus};
    case (ALU_Sel)
      6'd0:  w_alu = {32'd0, r_y + w_bus};
      6'd1:  w_alu = {32'd0, r_y - w_bus};
      6'd2:  w_alu = {32'd0, r_y & w_bus};
      6'd3:  w_alu = {32'd0, r_y | w_bus};
      6'd4:  w_alu = {32'd0, r_y >> w_shamt};
      6'd5:  w_alu = {32'd0, w_shra};
      6'd6:  w_alu = {32'd0, r_y << w_shamt};
      6'd7:  w_alu = {32'd0, w_ror};
      6'd8:  w_alu = {32'd0, w_rol};
      6'd9:  w_alu = w_prod;
      6'd10: w_alu = (w_bus == 32'd0) ? 64'd0 : {w_rem, w_quot};
      6'd11: w_alu = {32'd0, 32'd0 - w_bus};
      6'd12: w_alu = {32'd0, ~w_bus};
      default: w_alu = {32'd0, w_bus};
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (r_ir[20:19])
      2'b00: w_cond = (w_bus == 32'd0);
      2'b01: w_cond = (w_bus != 32'd0);
      2'b10: w_cond = !w_bus[31] && (w_bus != 32'd0);
      2'b11: w_cond = w_bus[31];
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_z       <= '0;
      r_pc      <= '0;
      r_ir      <= '0;
      r_mdr     <= '0;
      r_mar     <= '0;
      r_y       <= '0;
      r_inport  <= '0;
      r_outport <= '0;
      r_con     <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (reg_enable[i] || (Rin && (Gra == 4'(i)))) r_gpr[i] <= w_bus;
      if (reg_enable[16]) r_hi  <= w_bus;
      if (reg_enable[17]) r_lo  <= w_bus;
      if (incPC)               r_z <= {32'd0, w_bus + 32'd1};
      else if (reg_enable[19]) r_z <= w_alu;
      if (reg_enable[20]) r_pc  <= w_bus;
      if (reg_enable[21]) r_ir  <= w_bus;
      if (reg_enable[22]) r_mdr <= (read && !write) ? Mdatain : w_bus;
      if (reg_enable[23]) r_mar <= w_bus;
      if (reg_enable[24]) r_y   <= w_bus;
      if (strobeInport1)  r_inport  <= Mdatain;
      if (outport1Enable) r_outport <= w_bus;
      if (conIn)          r_con <= w_cond;
    end
  end

  assign CONFFOut = r_con;

  // MAR and OutPort feed devices outside this block
  assign w_unused = ^{Grc, r_outport, r_mar, r_ir[31:21], reg_enable[31:25],
                      reg_enable[18], enc_input};

endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// ============================================================================
// tb_datapath : vector-table bench for the single-bus datapath  -- rev 1.0
// ============================================================================
`default_nettype none

module tb_datapath;

  logic        clock;
  logic        clr;
  logic [31:0] bus_contents;
  logic [31:0] enc_input;
  logic [5:0]  ALU_Sel;
  logic [31:0] Mdatain;
  logic        read, write, incPC, Rin, Rout, BAout, conIn;
  logic        CONFFOut, outport1Enable, strobeInport1;
  logic [31:0] reg_enable;
  logic [3:0]  Gra, Grb, Grc;

  datapath dut (
    .clock(clock), .clr(clr), .bus_contents(bus_contents),
    .enc_input(enc_input), .ALU_Sel(ALU_Sel), .Mdatain(Mdatain),
    .read(read), .write(write), .reg_enable(reg_enable), .incPC(incPC),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .conIn(conIn), .CONFFOut(CONFFOut), .outport1Enable(outport1Enable),
    .strobeInport1(strobeInport1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int F_RD = 1, F_WR = 2, F_INC = 4, F_RIN = 8, F_ROUT = 16;
  localparam int F_BA = 32, F_CON = 64, F_STB = 128, F_OUT = 256, F_CLR = 512;

  typedef struct {
    logic [31:0] enc;
    logic [31:0] ren;
    logic [5:0]  alu;
    logic [31:0] md;
    int          fl;
    logic [3:0]  gra;
    logic [3:0]  grb;
    logic        cb;
    logic [31:0] eb;
    logic        cc;
    logic        ec;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] bus_q[$];
  logic        con_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] b(int n);
    return 32'd1 << n;
  endfunction

  function automatic void mk(logic [31:0] enc, logic [31:0] ren, logic [5:0] alu,
                             logic [31:0] md, int fl, logic [3:0] gra, logic [3:0] grb,
                             logic cb, logic [31:0] eb, logic cc, logic ec);
    vec_t v;
    v.enc = enc; v.ren = ren; v.alu = alu; v.md = md; v.fl = fl;
    v.gra = gra; v.grb = grb; v.cb = cb; v.eb = eb; v.cc = cc; v.ec = ec;
    vt.push_back(v);
  endfunction

  // shorthand: bus-checked step, InPort strobe, CON-checked step
  function automatic void bus(logic [31:0] enc, logic [31:0] ren, logic [5:0] alu,
                              int fl, logic [3:0] g, logic [31:0] eb);
    mk(enc, ren, alu, 32'd0, fl, g, g, 1'b1, eb, 1'b0, 1'b0);
  endfunction

  function automatic void stb(logic [31:0] md);
    mk(32'd0, 32'd0, 6'd13, md, F_STB, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endfunction

  function automatic void con(logic [31:0] enc, logic ec);
    mk(enc, 32'd0, 6'd13, 32'd0, F_CON, 4'd0, 4'd0, 1'b0, 32'd0, 1'b1, ec);
  endfunction

  task automatic apply(input vec_t v, input int idx);
    logic [31:0] eb;
    logic        ec;
    @(negedge clock);
    clr            = (v.fl & F_CLR)  != 0;
    read           = (v.fl & F_RD)   != 0;
    write          = (v.fl & F_WR)   != 0;
    incPC          = (v.fl & F_INC)  != 0;
    Rin            = (v.fl & F_RIN)  != 0;
    Rout           = (v.fl & F_ROUT) != 0;
    BAout          = (v.fl & F_BA)   != 0;
    conIn          = (v.fl & F_CON)  != 0;
    strobeInport1  = (v.fl & F_STB)  != 0;
    outport1Enable = (v.fl & F_OUT)  != 0;
    enc_input = v.enc; reg_enable = v.ren; ALU_Sel = v.alu; Mdatain = v.md;
    Gra = v.gra; Grb = v.grb; Grc = 4'hF;
    if (v.cb) bus_q.push_back(v.eb);
    if (v.cc) con_q.push_back(v.ec);
    #1;
    if (v.cb) begin
      eb = bus_q.pop_front();
      n_vec++;
      if (bus_contents !== eb) begin
        n_err++;
        $display("FAIL bus vec %0d: got %h want %h", idx, bus_contents, eb);
      end
    end
    @(posedge clock);
    #1;
    if (v.cc) begin
      ec = con_q.pop_front();
      n_vec++;
      if (CONFFOut !== ec) begin
        n_err++;
        $display("FAIL con vec %0d: got %b want %b", idx, CONFFOut, ec);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then dirty state, then reset again with loads competing
    mk(0, 0, 0, 0, F_CLR, 0, 0, 0, 0, 0, 0);
    stb(32'h0000_DEAD);
    bus(b(23), b(1) | b(20), 6'd13, 0, 0, 32'h0000_DEAD);
    con(0, 1'b1);
    mk(b(23), b(20) | b(1), 0, 32'h1, F_CLR | F_CON | F_STB, 1, 1, 0, 0, 1, 0);
    bus(0, 0, 0, 0, 0, 32'd0);
    bus(b(20), 0, 0, 0, 0, 32'd0);
    bus(0, 0, 0, F_ROUT, 1, 32'd0);
    bus(b(23), 0, 0, 0, 0, 32'd0);
    // Fetch
    stb(32'd5);
    bus(b(23), b(20), 13, 0, 0, 32'd5);
    bus(b(20), b(23), 13, F_INC, 0, 32'd5);
    bus(b(19), b(20), 13, 0, 0, 32'd6);
    mk(0, b(22), 13, 32'h1234_5678, F_RD, 0, 0, 1, 32'd0, 0, 0);
    bus(b(22), b(21), 13, 0, 0, 32'h1234_5678);
    bus(b(20), 0, 13, 0, 0, 32'd6);
    bus(b(25), 0, 13, 0, 0, 32'hFFFC_5678);
    // ADD with wrap
    stb(32'hFFFF_FFFB);
    bus(b(23), b(2), 13, 0, 0, 32'hFFFF_FFFB);
    stb(32'd7);
    bus(b(23), b(24), 13, 0, 0, 32'd7);
    bus(0, b(19), 0, F_ROUT, 2, 32'hFFFF_FFFB);
    bus(b(19), 0, 13, 0, 0, 32'd2);
    bus(b(18), 0, 13, 0, 0, 32'd0);
    // MUL -3*4
    stb(32'hFFFF_FFFD);
    bus(b(23), b(24), 13, 0, 0, 32'hFFFF_FFFD);
    stb(32'd4);
    bus(b(23), b(19), 9, 0, 0, 32'd4);
    bus(b(18), 0, 13, 0, 0, 32'hFFFF_FFFF);
    bus(b(19), 0, 13, 0, 0, 32'hFFFF_FFF4);
    // DIV 7/2 and divide by zero
    stb(32'd7);
    bus(b(23), b(24), 13, 0, 0, 32'd7);
    stb(32'd2);
    bus(b(23), b(19), 10, 0, 0, 32'd2);
    bus(b(19), 0, 13, 0, 0, 32'd3);
    bus(b(18), 0, 13, 0, 0, 32'd1);
    bus(0, b(19), 10, 0, 0, 32'd0);
    bus(b(18), 0, 13, 0, 0, 32'd0);
    bus(b(19), 0, 13, 0, 0, 32'd0);
    // SUB, NOT, ROR, pass-through; HI/LO as bus sources
    bus(b(23), b(19), 1, 0, 0, 32'd2);
    bus(b(19), b(17), 13, 0, 0, 32'd5);
    bus(b(23), b(19), 12, 0, 0, 32'd2);
    bus(b(19), b(16), 13, 0, 0, 32'hFFFF_FFFD);
    bus(b(17), 0, 13, 0, 0, 32'd5);
    bus(b(16), 0, 13, 0, 0, 32'hFFFF_FFFD);
    bus(b(23), b(19), 7, 0, 0, 32'd2);
    bus(b(19), 0, 13, 0, 0, 32'hC000_0001);
    bus(b(23), b(19), 13, 0, 0, 32'd2);
    bus(b(19), 0, 13, 0, 0, 32'd2);
    // incPC wraps and overrides the ALU load
    stb(32'hFFFF_FFFF);
    bus(b(23), b(19), 0, F_INC, 0, 32'hFFFF_FFFF);
    bus(b(19), 0, 13, 0, 0, 32'd0);
    // InPort -> R1 via Rin, priority, multi-target loads
    stb(32'h0000_00AA);
    bus(b(23), 0, 13, F_RIN, 1, 32'h0000_00AA);
    bus(0, 0, 13, F_ROUT, 1, 32'h0000_00AA);
    bus(b(23), 0, 13, F_ROUT, 2, 32'hFFFF_FFFB);
    bus(b(2) | b(20), 0, 13, 0, 0, 32'hFFFF_FFFB);
    bus(b(21) | b(20), 0, 13, 0, 0, 32'd6);
    bus(b(23), b(4), 13, F_RIN, 3, 32'h0000_00AA);
    bus(0, 0, 13, F_ROUT, 3, 32'h0000_00AA);
    bus(b(4), 0, 13, 0, 0, 32'h0000_00AA);
    // write forces MDR to take the bus even with read set
    mk(b(23), b(22), 13, 32'h55, F_RD | F_WR | F_OUT, 0, 0, 1, 32'hAA, 0, 0);
    bus(b(22), 0, 13, 0, 0, 32'h0000_00AA);
    // CON conditions
    stb(32'd0);
    bus(b(23), b(21), 13, 0, 0, 32'd0);
    con(0, 1'b1);
    stb(32'd5);
    con(b(23), 1'b0);
    stb(32'h0008_0000);
    bus(b(23), b(21), 13, 0, 0, 32'h0008_0000);
    con(b(23), 1'b1);
    con(0, 1'b0);
    stb(32'h0010_0000);
    bus(b(23), b(21), 13, 0, 0, 32'h0010_0000);
    stb(32'h8000_0000);
    con(b(23), 1'b0);
    stb(32'd3);
    con(b(23), 1'b1);
    stb(32'h0018_0000);
    bus(b(23), b(21), 13, 0, 0, 32'h0018_0000);
    con(b(23), 1'b0);
    stb(32'h8000_0000);
    con(b(23), 1'b1);
    // BAout
    stb(32'd9);
    bus(b(23), b(0), 13, 0, 0, 32'd9);
    bus(0, 0, 13, F_BA, 0, 32'd0);
    bus(0, 0, 13, F_ROUT, 0, 32'd9);
    bus(b(23), 0, 13, F_BA, 1, 32'h0000_00AA);

    foreach (vt[i]) apply(vt[i], i);

    if (bus_q.size() != 0 || con_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d bus and %0d con entries left, want 0",
               bus_q.size(), con_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
